// File: rtl/a2bus_write_capture.sv
// Captures qualifying Apple II bus cycles into a first-word-fall-through FIFO
// that a downstream consumer drains through a valid/ready handshake.
module a2bus_write_capture #(
    parameter int unsigned DEPTH         = 16,
    parameter logic [15:0] ADDR_LO       = 16'hC000,
    parameter logic [15:0] ADDR_HI       = 16'hC0FF,
    parameter bit          CAPTURE_READS = 1'b0
) (
    input  logic                     clk_logic_i,
    input  logic                     system_reset_n_i,
    input  logic [15:0]              addr_i,
    input  logic [7:0]               data_i,
    input  logic                     rw_n_i,
    input  logic                     m2sel_n_i,
    input  logic                     data_in_strobe_i,
    input  logic                     clear_i,
    input  logic                     out_ready_i,
    output logic                     out_valid_o,
    output logic                     out_rw_n_o,
    output logic [15:0]              out_addr_o,
    output logic [7:0]               out_data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    output logic [7:0]               drop_count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    typedef struct packed {
        logic        rw_n;
        logic [15:0] addr;
        logic [7:0]  data;
    } rec_t;

    rec_t          mem [DEPTH];
    rec_t          head;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    logic          qualify, valid, full, push, pop, drop, write_en;

    assign qualify = data_in_strobe_i & ~m2sel_n_i
                   & (addr_i >= ADDR_LO) & (addr_i <= ADDR_HI)
                   & (~rw_n_i | CAPTURE_READS);
    assign valid    = (level_q != '0);
    assign full     = (level_q == FULL_LEVEL);
    assign pop      = valid & out_ready_i;
    // A full FIFO still accepts a record when the head leaves in the same cycle.
    assign push     = qualify & (~full | pop);
    assign drop     = qualify & full & ~pop;
    assign write_en = push & ~clear_i;

    // NOTE: every always_comb output gets a default first, so no path leaves a latch.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clear_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_logic_i or negedge system_reset_n_i) begin
        if (!system_reset_n_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // NOTE: storage has no reset; level_q gates every read, so stale contents never escape.
    always_ff @(posedge clk_logic_i) begin
        if (write_en) mem[wr_ptr_q] <= '{rw_n: rw_n_i, addr: addr_i, data: data_i};
    end

    assign head         = mem[rd_ptr_q];
    assign out_valid_o  = valid;
    assign out_rw_n_o   = valid & head.rw_n;
    assign out_addr_o   = valid ? head.addr : 16'h0000;
    assign out_data_o   = valid ? head.data : 8'h00;
    assign level_o      = level_q;
    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_cnt_q;

endmodule

// File: tb/tb_a2bus_write_capture.sv
// Directed bench for a2bus_write_capture: a DEPTH=16 instance (a) and a DEPTH=4
// instance (b) share bus inputs but have independent strobes and ready lines.
module tb_a2bus_write_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw_n, m2sel_n, clear;
    logic        stb_a, rdy_a, stb_b, rdy_b;

    logic        a_valid, a_rw_n, a_overflow;
    logic [15:0] a_addr;
    logic [7:0]  a_data, a_drop;
    logic [4:0]  a_level;
    logic        b_valid, b_rw_n, b_overflow;
    logic [15:0] b_addr;
    logic [7:0]  b_data, b_drop;
    logic [2:0]  b_level;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    a2bus_write_capture #(.DEPTH(16)) dut_a (
        .clk_logic_i(clk), .system_reset_n_i(rst_n),
        .addr_i(addr), .data_i(data), .rw_n_i(rw_n), .m2sel_n_i(m2sel_n),
        .data_in_strobe_i(stb_a), .clear_i(clear), .out_ready_i(rdy_a),
        .out_valid_o(a_valid), .out_rw_n_o(a_rw_n), .out_addr_o(a_addr),
        .out_data_o(a_data), .level_o(a_level), .overflow_o(a_overflow),
        .drop_count_o(a_drop)
    );

    a2bus_write_capture #(.DEPTH(4)) dut_b (
        .clk_logic_i(clk), .system_reset_n_i(rst_n),
        .addr_i(addr), .data_i(data), .rw_n_i(rw_n), .m2sel_n_i(m2sel_n),
        .data_in_strobe_i(stb_b), .clear_i(clear), .out_ready_i(rdy_b),
        .out_valid_o(b_valid), .out_rw_n_o(b_rw_n), .out_addr_o(b_addr),
        .out_data_o(b_data), .level_o(b_level), .overflow_o(b_overflow),
        .drop_count_o(b_drop)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        n_cmp++;
        assert (obs === 32'(exp)) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic [15:0] a, input logic rw, input logic sel,
                       input logic [7:0] d, input logic to_a, input logic to_b);
        addr    = a;
        rw_n    = rw;
        m2sel_n = sel;
        data    = d;
        stb_a   = to_a;
        stb_b   = to_b;
        tick();
        stb_a = 1'b0;
        stb_b = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; addr = '0; data = '0; rw_n = 1'b1; m2sel_n = 1'b1;
        clear = 1'b0; stb_a = 1'b0; rdy_a = 1'b0; stb_b = 1'b0; rdy_b = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_valid", 32'(a_valid), 0);
        check("rst_addr", 32'(a_addr), 0);
        check("rst_level", 32'(a_level), 0);
        check("rst_overflow", 32'(a_overflow), 0);
        check("rst_drop", 32'(a_drop), 0);
        rst_n = 1'b1;
        tick();

        // Single write, then pop.
        bus(16'hC054, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("push_valid", 32'(a_valid), 1);
        check("push_addr", 32'(a_addr), 'hC054);
        check("push_rw", 32'(a_rw_n), 0);
        check("push_data", 32'(a_data), 0);
        check("push_level", 32'(a_level), 1);
        rdy_a = 1'b1;
        tick();
        rdy_a = 1'b0;
        check("pop_valid", 32'(a_valid), 0);
        check("pop_level", 32'(a_level), 0);
        check("pop_addr_zero", 32'(a_addr), 0);

        // Filtering.
        bus(16'hBFFF, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0);
        bus(16'hC030, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0);
        bus(16'hC080, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0);
        check("filter_level", 32'(a_level), 0);
        check("filter_valid", 32'(a_valid), 0);
        bus(16'hC0FF, 1'b0, 1'b0, 8'h44, 1'b1, 1'b0);
        bus(16'hC100, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0);
        check("edge_level", 32'(a_level), 1);
        check("edge_addr", 32'(a_addr), 'hC0FF);
        check("edge_data", 32'(a_data), 'h44);
        rdy_a = 1'b1;
        tick();
        rdy_a = 1'b0;
        check("edge_drained", 32'(a_level), 0);

        // Overflow: 20 writes into 16 entries.
        for (int i = 0; i < 20; i++) bus(16'hC000 + 16'(i), 1'b0, 1'b0, 8'(i), 1'b1, 1'b0);
        check("ovf_level", 32'(a_level), 16);
        check("ovf_flag", 32'(a_overflow), 1);
        check("ovf_drop", 32'(a_drop), 4);
        rdy_a = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("ovf_drain_valid", 32'(a_valid), 1);
            check("ovf_drain_addr", 32'(a_addr), 'hC000 + i);
            check("ovf_drain_data", 32'(a_data), i);
            tick();
        end
        rdy_a = 1'b0;
        check("ovf_empty", 32'(a_valid), 0);
        check("ovf_sticky", 32'(a_overflow), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_overflow", 32'(a_overflow), 0);
        check("clr_drop", 32'(a_drop), 0);

        // Full FIFO with a simultaneous push and pop.
        for (int i = 0; i < 16; i++) bus(16'hC000 + 16'(i), 1'b0, 1'b0, 8'(i), 1'b1, 1'b0);
        check("full_level", 32'(a_level), 16);
        rdy_a = 1'b1;
        bus(16'hC0AA, 1'b0, 1'b0, 8'hAA, 1'b1, 1'b0);
        rdy_a = 1'b0;
        check("pp_level", 32'(a_level), 16);
        check("pp_drop", 32'(a_drop), 0);
        check("pp_overflow", 32'(a_overflow), 0);
        rdy_a = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("pp_drain_addr", 32'(a_addr), (i < 15) ? 'hC001 + i : 'hC0AA);
            tick();
        end
        rdy_a = 1'b0;
        check("pp_empty", 32'(a_level), 0);

        // DEPTH=4 pointer wrap with alternating push and pop.
        for (int k = 0; k < 20; k++) begin
            bus(16'hC000 + 16'(k), 1'b0, 1'b0, 8'(k), 1'b0, 1'b1);
            check("wrap_level_push", 32'(b_level), 1);
            check("wrap_addr", 32'(b_addr), 'hC000 + k);
            rdy_b = 1'b1;
            tick();
            rdy_b = 1'b0;
            check("wrap_level_pop", 32'(b_level), 0);
        end

        // 4 fills then 300 drops: counter saturates.
        for (int i = 0; i < 304; i++)
            bus(16'hC000 + 16'(i & 'hFF), 1'b0, 1'b0, 8'(i), 1'b0, 1'b1);
        check("sat_drop", 32'(b_drop), 255);
        check("sat_overflow", 32'(b_overflow), 1);
        check("sat_level", 32'(b_level), 4);
        check("sat_head", 32'(b_addr), 'hC000);

        // Clear beats a coincident strobe.
        clear = 1'b1;
        bus(16'hC0EE, 1'b0, 1'b0, 8'hEE, 1'b0, 1'b1);
        clear = 1'b0;
        check("clrstb_level", 32'(b_level), 0);
        check("clrstb_overflow", 32'(b_overflow), 0);
        check("clrstb_drop", 32'(b_drop), 0);
        check("clrstb_valid", 32'(b_valid), 0);

        // Asynchronous reset while holding records.
        for (int i = 0; i < 5; i++) bus(16'hC010 + 16'(i), 1'b0, 1'b0, 8'(i), 1'b1, 1'b0);
        check("hold_level", 32'(a_level), 5);
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(a_valid), 0);
        check("arst_level", 32'(a_level), 0);
        check("arst_overflow", 32'(a_overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus(16'hC012, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0);
        check("post_valid", 32'(a_valid), 1);
        check("post_addr", 32'(a_addr), 'hC012);
        check("post_data", 32'(a_data), 'h5A);
        check("post_level", 32'(a_level), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/a2bus_write_capture.md
# a2bus_write_capture

Downstream consumer of the Apple II bus sampler. Watches the sampled address/data/rw stream, selects qualifying cycles (default: writes to the $C000-$C0FF soft-switch page), and queues each one as a {rw_n, addr, data} record in a small FIFO. Cards and the soft-switch/video tracking logic drain the FIFO at their own pace through a valid/ready handshake. The FIFO also reports its fill level and counts dropped records.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256
- ADDR_LO, 16'hC000, inclusive lower bound of the capture window
- ADDR_HI, 16'hC0FF, inclusive upper bound of the capture window
- CAPTURE_READS, 0, 1 = also capture read cycles (rw_n=1) in the window

Ports:
- clk_logic_i  in  1  logic clock; everything is on its rising edge
- system_reset_n_i  in  1  asynchronous, active-low reset
- addr_i  in  16  sampled bus address, stable across the strobe
- data_i  in  8  sampled bus data
- rw_n_i  in  1  sampled R/W (0 = write)
- m2sel_n_i  in  1  main-bus select; a cycle qualifies only when this is 0
- data_in_strobe_i  in  1  one-cycle pulse per bus cycle, sent once data is valid
- clear_i  in  1  synchronous flush of FIFO and overflow state
- out_ready_i  in  1  consumer accepts the head record
- out_valid_o  out  1  head record is present
- out_rw_n_o  out  1  head record R/W
- out_addr_o  out  16  head record address
- out_data_o  out  8  head record data
- level_o  out  $clog2(DEPTH)+1  entries currently held
- overflow_o  out  1  sticky flag: at least one record was dropped
- drop_count_o  out  8  number of dropped records, saturates at 255

## Operation
- Qualify: `q = data_in_strobe_i & ~m2sel_n_i & (addr_i >= ADDR_LO) & (addr_i <= ADDR_HI) & (~rw_n_i | CAPTURE_READS)`. Unsigned 16-bit compares.
- Push: q and not full (level_o < DEPTH), or q and full with a pop in the same cycle. Writes {rw_n_i, addr_i, data_i} at wr_ptr, then wr_ptr advances. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Pop: out_valid_o & out_ready_i. rd_ptr advances. out_ready_i is ignored while out_valid_o = 0.
- Level updates:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- Drop: q while full and no pop in that cycle.
  - overflow_o is set.
  - drop_count_o increments, saturating at 8'hFF.
  - FIFO contents are unchanged.
- clear_i: sets pointers, level_o, overflow_o and drop_count_o to 0. Clear has priority over push, pop and drop in the same cycle; a coincident strobe is discarded and is not counted as a drop.
- Output is first-word-fall-through. out_* shows mem[rd_ptr] when out_valid_o = 1. out_rw_n_o, out_addr_o and out_data_o are forced to 0 when out_valid_o = 0.
- data_i is recorded as presented, including on read cycles. Consumers treat read-record data as meaningless.
- Strobe is level-sampled: every cycle it is high counts as an event. Upstream guarantees a one-cycle pulse.
- Storage array has no reset. All pointers, counters and flags do.

## Timing
- Reset values (async assert, sync release):
  - out_valid_o = 0, out_* = 0
  - level_o = 0
  - overflow_o = 0, drop_count_o = 0
- Push latency:
  - Strobe sampled at edge k into an empty FIFO: out_valid_o = 1 and out_* valid after edge k.
  - level_o reflects the push after edge k.
- Pop: ready sampled high at edge k with valid high. The next record, or out_valid_o = 0, appears after edge k.
- Throughput: one push and one pop per clock, sustained.
- Reset asserted mid-operation: all queued records are lost immediately. The first strobe after release is captured normally.
- Bus strobes arrive at most once per ~1 µs bus cycle. The FIFO only overflows if the consumer stalls for about DEPTH bus cycles.

## Test plan
- Reset, then write $C054 data $00 (rw_n=0, m2sel_n=0), strobe. Required: out_valid_o=1 one cycle later, out_addr_o=16'hC054, out_rw_n_o=0, level_o=1. Ready=1 gives out_valid_o=0, level_o=0.
- Filtering:
  - Write $BFFF, read $C030 (CAPTURE_READS=0), write $C080 with m2sel_n=1: no records, level_o stays 0.
  - Write $C100 after $C0FF: exactly one record, $C0FF.
- Ready held 0, DEPTH=16, 20 qualifying writes $C000..$C013. Required:
  - level_o=16, overflow_o=1, drop_count_o=4.
  - Draining gives $C000..$C00F in order with no duplicates.
- Fill to 16 entries, then in one cycle strobe $C0AA with ready=1. Required: level_o stays 16, no drop, $C0AA is the last record drained.
- Pointer wrap: 40 alternating push/pop cycles with DEPTH=4. Order is preserved, level_o ≤ 1.
  - Then 300 drops with ready=0: drop_count_o=255, not wrapping.
  - clear_i asserted together with a strobe: level_o=0, overflow_o=0, drop_count_o=0, strobe not recorded.
- system_reset_n_i pulsed low while holding 5 records. Required: out_valid_o, level_o and overflow_o go 0 immediately. A write after release is captured.
